// File: rtl/id_hazard_scoreboard.sv
// ============================================================================
// Module   : id_hazard_scoreboard
// Purpose  : ID-stage operand resolution with multi-stage forwarding,
//            load-use detection and a long-latency writer scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_hazard_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int CW      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_en,
  input  logic [NUM_SRC*AW-1:0]  src_addr,
  input  logic [NUM_SRC*DW-1:0]  rf_rdata,
  input  logic [NUM_FWD-1:0]     fwd_we,
  input  logic [NUM_FWD*AW-1:0]  fwd_waddr,
  input  logic [NUM_FWD*DW-1:0]  fwd_wdata,
  input  logic [NUM_FWD-1:0]     fwd_rdy,
  input  logic                   wb_we,
  input  logic [AW-1:0]          wb_waddr,
  input  logic [DW-1:0]          wb_wdata,
  input  logic                   issue_fire,
  input  logic                   issue_we,
  input  logic                   issue_long,
  input  logic [AW-1:0]          issue_waddr,
  input  logic                   lc_valid,
  input  logic [AW-1:0]          lc_waddr,
  input  logic [DW-1:0]          lc_wdata,
  input  logic                   sb_clear,
  output logic [NUM_SRC*DW-1:0]  opnd,
  output logic                   stallreq,
  output logic                   sb_busy,
  output logic                   sb_err,
  output logic [CW-1:0]          stall_cnt
);

  localparam int DEPTH = 1 << AW;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]   pend_q, pend_d;
  logic               sb_err_q, sb_err_d;
  logic [CW-1:0]      stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0] src_stall;
  logic               waw_stall;
  logic               issue_nz;
  logic               issue_lc_hit;
  logic               issue_eff;

  // --------------------------------------------------------------------------
  // Per-source operand mux and hazard terms
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    logic [AW-1:0] addr;
    logic          addr_nz;
    logic          lc_hit;
    logic          fwd_hit;
    logic          fwd_hit_rdy;
    logic [DW-1:0] fwd_val;
    logic          wb_hit;
    logic [DW-1:0] opnd_val;
    logic          stall_term;

    always_comb begin
      addr        = src_addr[j*AW +: AW];
      addr_nz     = (addr != '0);
      lc_hit      = addr_nz && lc_valid && (lc_waddr == addr);
      wb_hit      = addr_nz && wb_we && (wb_waddr == addr);
      fwd_hit     = 1'b0;
      fwd_hit_rdy = 1'b1;
      fwd_val     = '0;
      // Youngest matching stage owns the register; older stages are shadowed.
      for (int k = 0; k < NUM_FWD; k++) begin
        if (addr_nz && !fwd_hit && fwd_we[k] && (fwd_waddr[k*AW +: AW] == addr)) begin
          fwd_hit     = 1'b1;
          fwd_hit_rdy = fwd_rdy[k];
          fwd_val     = fwd_wdata[k*DW +: DW];
        end
      end

      if (!addr_nz) begin
        opnd_val = '0;
      end else if (lc_hit) begin
        opnd_val = lc_wdata;
      end else if (fwd_hit) begin
        opnd_val = fwd_val;
      end else if (wb_hit) begin
        opnd_val = wb_wdata;
      end else begin
        opnd_val = rf_rdata[j*DW +: DW];
      end

      stall_term = src_en[j] && addr_nz &&
                   ((fwd_hit && !fwd_hit_rdy) || (pend_q[addr] && !lc_hit));
    end

    assign opnd[j*DW +: DW] = opnd_val;
    assign src_stall[j]     = stall_term;
  end

  // --------------------------------------------------------------------------
  // WAW against an outstanding long writer, and overall stall
  // --------------------------------------------------------------------------
  always_comb begin
    issue_nz     = (issue_waddr != '0);
    issue_lc_hit = lc_valid && (lc_waddr == issue_waddr);
    waw_stall    = issue_we && issue_nz && pend_q[issue_waddr] && !issue_lc_hit;
    stallreq     = (|src_stall) || waw_stall;
    issue_eff    = issue_fire && !stallreq;
  end

  // --------------------------------------------------------------------------
  // Next-state for scoreboard, error flag and stall counter
  // --------------------------------------------------------------------------
  always_comb begin
    pend_d      = pend_q;
    sb_err_d    = sb_err_q;
    stall_cnt_d = stall_cnt_q;

    if (sb_clear) begin
      pend_d = '0;
    end else begin
      if (lc_valid) begin
        if (!pend_q[lc_waddr]) begin
          sb_err_d = 1'b1;
        end
        pend_d[lc_waddr] = 1'b0;
      end
      // Applied after the clear so a new writer to the same register wins.
      if (issue_eff && issue_long && issue_nz) begin
        pend_d[issue_waddr] = 1'b1;
      end
    end

    if (stallreq && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= '0;
      sb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      sb_err_q    <= sb_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb_busy   = |pend_q;
  assign sb_err    = sb_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire
